sm4_iter_ctrl: RTL and testbench

- Sequential SM4 engine and controller that time-multiplexes one shared round-function datapath across two uses: key expansion and the 32 data rounds.
- Handles both encryption and decryption per block, with valid/ready handshakes on the key, input and output sides.
- Replaces the fully unrolled combinational sm4_en/sm4_de for area-constrained integration, and must be bit-exact with them.

---
 rtl/sm4_pkg.sv | 54 +++++
 rtl/sm4_round.sv | 19 +
 rtl/sm4_iter_ctrl.sv | 130 +++++++++++++
 tb/tb_sm4_iter_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 constants and the round building blocks tau, L (data) and L' (key schedule).
package sm4_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {IDLE, KEYEXP, RUN, HOLD} state_t;

    localparam logic [0:3][31:0] FK = {32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

    localparam logic [0:31][31:0] CK = {
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    // Element 0 sits in the most significant byte, so SBOX[x] reads row-major.
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic word_t tau(input word_t a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    function automatic word_t l_data(input word_t b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    function automatic word_t l_key(input word_t b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_round.sv
// One SM4 round: y = x0 ^ Lsel(tau(x1 ^ x2 ^ x3 ^ rk)); key_mode picks L' for the key schedule.
module sm4_round
    import sm4_pkg::*;
(
    input  word_t x0,
    input  word_t x1,
    input  word_t x2,
    input  word_t x3,
    input  word_t rk,
    input  logic  key_mode,
    output word_t y
);

    word_t t;

    assign t = tau(x1 ^ x2 ^ x3 ^ rk);
    assign y = x0 ^ (key_mode ? l_key(t) : l_data(t));

endmodule

// File: rtl/sm4_iter_ctrl.sv
// Iterative SM4 engine: UNROLL chained rounds shared between key expansion and encrypt/decrypt.
module sm4_iter_ctrl
    import sm4_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         keys_loaded
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("sm4_iter_ctrl: UNROLL must be 1, 2 or 4");
    end

    localparam logic [4:0] STEP = 5'(UNROLL);
    localparam logic [4:0] LAST = 5'(32 - UNROLL);

    state_t          state, state_d;
    logic [4:0]      ctr;
    logic [3:0][31:0] x_q;            // x_q[0] is the oldest word of the sliding window
    logic            dec_q;
    word_t           rk_q [0:31];
    logic            key_acc, in_acc, last, key_mode;
    logic [3:0][31:0] ch [0:UNROLL];

    assign last     = (ctr == LAST);
    assign key_mode = (state == KEYEXP);
    assign ch[0]    = x_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
        logic [4:0] idx;
        word_t      rk_u, y;

        assign idx  = ctr + 5'(u);
        assign rk_u = key_mode ? CK[idx] : (dec_q ? rk_q[5'd31 - idx] : rk_q[idx]);

        sm4_round u_round (
            .x0(ch[u][0]), .x1(ch[u][1]), .x2(ch[u][2]), .x3(ch[u][3]),
            .rk(rk_u), .key_mode(key_mode), .y(y)
        );

        assign ch[u+1] = {y, ch[u][3], ch[u][2], ch[u][1]};
    end

    always_comb begin
        state_d   = state;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        key_acc   = 1'b0;
        in_acc    = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                in_ready  = keys_loaded && !key_valid;   // a pending key always wins
                key_acc   = key_valid;
                in_acc    = in_valid && keys_loaded && !key_valid;
                if (key_acc)     state_d = KEYEXP;
                else if (in_acc) state_d = RUN;
            end
            KEYEXP:  if (last) state_d = IDLE;
            RUN:     if (last) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr         <= '0;
            x_q         <= '0;
            dec_q       <= 1'b0;
            keys_loaded <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_acc) begin
                        for (int k = 0; k < 4; k++) x_q[k] <= key[127-32*k -: 32] ^ FK[k];
                        keys_loaded <= 1'b0;
                        ctr         <= '0;
                    end else if (in_acc) begin
                        for (int k = 0; k < 4; k++) x_q[k] <= in_data[127-32*k -: 32];
                        dec_q <= in_decrypt;
                        ctr   <= '0;
                    end
                end
                KEYEXP: begin
                    x_q <= ch[UNROLL];
                    ctr <= ctr + STEP;
                    if (last) keys_loaded <= 1'b1;
                end
                RUN: begin
                    x_q <= ch[UNROLL];
                    ctr <= ctr + STEP;
                    // Window after round 31 is {X35,X34,X33,X32}, already in output order.
                    if (last) begin
                        out_data  <= ch[UNROLL];
                        out_valid <= 1'b1;
                    end
                end
                HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Round-key store has no reset; keys_loaded alone says whether it is usable.
    always_ff @(posedge clk) begin
        if (state == KEYEXP)
            for (int u = 0; u < UNROLL; u++) rk_q[ctr + 5'(u)] <= ch[u+1][3];
    end

endmodule

// File: tb/tb_sm4_iter_ctrl.sv
// Bench for sm4_iter_ctrl: known-answer vectors, handshake timing, and random blocks vs a loop-based SM4 model.
module tb_sm4_iter_ctrl;
    import sm4_pkg::*;

    localparam logic [127:0] K0 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] C0 = 128'h681edf34d206965e86b3e94f536e4246;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   key_valid, in_valid, in_decrypt, out_ready;
    wire  [2:0]   key_ready, in_ready, out_valid, keys_loaded;
    logic [127:0] key_a [3];
    logic [127:0] in_data_a [3];
    wire  [127:0] out_data_a [3];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    sm4_iter_ctrl #(.UNROLL(1)) u1 (
        .clk(clk), .rst(rst), .key_valid(key_valid[0]), .key_ready(key_ready[0]), .key(key_a[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_decrypt(in_decrypt[0]), .in_data(in_data_a[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data_a[0]), .keys_loaded(keys_loaded[0]));
    sm4_iter_ctrl #(.UNROLL(2)) u2 (
        .clk(clk), .rst(rst), .key_valid(key_valid[1]), .key_ready(key_ready[1]), .key(key_a[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_decrypt(in_decrypt[1]), .in_data(in_data_a[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data_a[1]), .keys_loaded(keys_loaded[1]));
    sm4_iter_ctrl #(.UNROLL(4)) u4 (
        .clk(clk), .rst(rst), .key_valid(key_valid[2]), .key_ready(key_ready[2]), .key(key_a[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_decrypt(in_decrypt[2]), .in_data(in_data_a[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data_a[2]), .keys_loaded(keys_loaded[2]));

    function automatic int unroll_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    // Reference SM4, written straight from the algorithm as word arrays.
    function automatic logic [31:0] rol(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] tfun(input logic [31:0] a, input bit keysch);
        logic [31:0] b;
        for (int i = 0; i < 4; i++) b[8*i +: 8] = SBOX[a[8*i +: 8]];
        if (keysch) return b ^ rol(b, 13) ^ rol(b, 23);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] ref_rk(input logic [127:0] mk, input int r);
        logic [31:0] k [36];
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ FK[i];
        for (int i = 0; i < 32; i++) k[i+4] = k[i] ^ tfun(k[i+1] ^ k[i+2] ^ k[i+3] ^ CK[i], 1'b1);
        return k[r+4];
    endfunction

    function automatic logic [127:0] ref_sm4(input logic [127:0] mk, input logic [127:0] d, input bit dec);
        logic [31:0] rk [32];
        logic [31:0] x [36];
        for (int i = 0; i < 32; i++) rk[i] = ref_rk(mk, i);
        for (int i = 0; i < 4; i++) x[i] = d[127-32*i -: 32];
        for (int j = 0; j < 32; j++)
            x[j+4] = x[j] ^ tfun(x[j+1] ^ x[j+2] ^ x[j+3] ^ (dec ? rk[31-j] : rk[j]), 1'b0);
        return {x[35], x[34], x[33], x[32]};
    endfunction

    task automatic load_key(input int i, input logic [127:0] k, output int kc);
        int n;
        @(negedge clk); key_a[i] = k; key_valid[i] = 1'b1;
        n = 0;
        while (!key_ready[i] && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1 key_valid[i] = 1'b0;
        kc = 0;
        while (!keys_loaded[i] && kc < 200) begin @(posedge clk); #1 kc++; end
    endtask

    task automatic run_block(input int i, input bit dec, input logic [127:0] d,
                             output logic [127:0] res, output int lat);
        int n;
        @(negedge clk); in_data_a[i] = d; in_decrypt[i] = dec; in_valid[i] = 1'b1; out_ready[i] = 1'b0;
        n = 0;
        while (!in_ready[i] && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1 in_valid[i] = 1'b0;
        lat = 1;
        while (!out_valid[i] && lat < 200) begin @(posedge clk); #1 lat++; end
        res = out_data_a[i];
        @(negedge clk); out_ready[i] = 1'b1;
        @(negedge clk); out_ready[i] = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (key_ready[i] !== 1'b1 || in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || keys_loaded[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d] got kr=%b ir=%b ov=%b kl=%b want 1 0 0 0",
                         i, key_ready[i], in_ready[i], out_valid[i], keys_loaded[i]);
            end
            checks++;
            if (out_data_a[i] !== 128'h0) begin
                errors++; $display("FAIL reset_out_data[%0d] got %h want 0", i, out_data_a[i]);
            end
        end
        checks++;
        if (u1.ctr !== 5'd0) begin errors++; $display("FAIL reset_ctr got %0d want 0", u1.ctr); end
    endtask

    task automatic test_key_priority;
        logic seen;
        int   kc, lat;
        @(negedge clk); in_data_a[0] = K0; in_decrypt[0] = 1'b0; in_valid[0] = 1'b1;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); seen |= in_ready[0] | out_valid[0]; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL no_key_accept got in_ready/out_valid=1 want 0"); end
        key_a[0] = K0; key_valid[0] = 1'b1;
        #1;
        checks++;
        if (in_ready[0] !== 1'b0 || key_ready[0] !== 1'b1) begin
            errors++; $display("FAIL key_wins got ir=%b kr=%b want 0 1", in_ready[0], key_ready[0]);
        end
        @(posedge clk); #1 key_valid[0] = 1'b0;
        checks++;
        if (key_ready[0] !== 1'b0) begin errors++; $display("FAIL keyexp_key_ready got %b want 0", key_ready[0]); end
        kc = 0; seen = 1'b0;
        while (!keys_loaded[0] && kc < 200) begin
            @(posedge clk); #1 kc++;
            if (!keys_loaded[0]) seen |= in_ready[0];
        end
        checks++;
        if (kc !== 32) begin errors++; $display("FAIL keyexp_cycles got %0d want 32", kc); end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL keyexp_in_ready got 1 want 0"); end
        checks++;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL in_ready_after_key got %b want 1", in_ready[0]); end
        @(posedge clk); #1 in_valid[0] = 1'b0;
        lat = 1;
        while (!out_valid[0] && lat < 200) begin @(posedge clk); #1 lat++; end
        checks++;
        if (out_data_a[0] !== C0) begin errors++; $display("FAIL encrypt_kat got %h want %h", out_data_a[0], C0); end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL encrypt_latency got %0d want 33", lat); end
        @(negedge clk); out_ready[0] = 1'b1;
        @(negedge clk); out_ready[0] = 1'b0;
    endtask

    task automatic test_decrypt;
        logic [127:0] res;
        int lat;
        run_block(0, 1'b1, C0, res, lat);
        checks++;
        if (res !== K0) begin errors++; $display("FAIL decrypt_kat got %h want %h", res, K0); end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL decrypt_latency got %0d want 33", lat); end
        checks++;
        if (u1.rk_q[0] !== 32'hf12186f9) begin errors++; $display("FAIL rk0 got %h want f12186f9", u1.rk_q[0]); end
        checks++;
        if (u1.rk_q[31] !== 32'h9124a012) begin errors++; $display("FAIL rk31 got %h want 9124a012", u1.rk_q[31]); end
        for (int r = 1; r < 31; r++) begin
            checks++;
            if (u1.rk_q[r] !== ref_rk(K0, r)) begin
                errors++; $display("FAIL rk%0d got %h want %h", r, u1.rk_q[r], ref_rk(K0, r));
            end
        end
    endtask

    task automatic test_hold;
        logic [127:0] held;
        int n;
        @(negedge clk); in_data_a[0] = K0; in_decrypt[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        n = 0;
        while (!in_ready[0] && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1 in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 200) begin @(posedge clk); #1 n++; end
        held = out_data_a[0];
        checks++;
        if (held !== C0) begin errors++; $display("FAIL hold_data got %h want %h", held, C0); end
        @(negedge clk); in_data_a[0] = C0; in_decrypt[0] = 1'b1; in_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b1 || out_data_a[0] !== held || in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got ov=%b ir=%b data=%h want 1 0 %h",
                         c, out_valid[0], in_ready[0], out_data_a[0], held);
            end
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1 out_ready[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++; $display("FAIL hold_release got ov=%b ir=%b want 0 1", out_valid[0], in_ready[0]);
        end
        @(posedge clk); #1 in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 200) begin @(posedge clk); #1 n++; end
        checks++;
        if (out_data_a[0] !== K0) begin errors++; $display("FAIL hold_next_block got %h want %h", out_data_a[0], K0); end
        @(negedge clk); out_ready[0] = 1'b1;
        @(negedge clk); out_ready[0] = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc, a0, a1, n;
        @(negedge clk); in_data_a[0] = K0; in_decrypt[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        cyc = 0; a0 = -1; a1 = -1;
        while (a1 < 0 && cyc < 200) begin
            if (in_ready[0]) begin
                if (a0 < 0) a0 = cyc;
                else        a1 = cyc;
            end
            @(negedge clk); cyc++;
        end
        in_valid[0] = 1'b0;
        checks++;
        if (a1 - a0 !== 34) begin errors++; $display("FAIL throughput got %0d want 34", a1 - a0); end
        n = 0;
        while (!out_valid[0] && n < 200) begin @(posedge clk); #1 n++; end
        checks++;
        if (out_data_a[0] !== C0) begin errors++; $display("FAIL b2b_data got %h want %h", out_data_a[0], C0); end
        @(negedge clk); @(negedge clk); out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_midrun;
        logic [127:0] res;
        logic seen;
        int n, kc, lat;
        @(negedge clk); in_data_a[0] = K0; in_decrypt[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        n = 0;
        while (!in_ready[0] && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1 in_valid[0] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (u1.ctr !== 5'd15) begin errors++; $display("FAIL midrun_round got %0d want 15", u1.ctr); end
        @(negedge clk); rst = 1'b1;
        #1;
        checks++;
        if (key_ready[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 || keys_loaded[0] !== 1'b0
            || out_data_a[0] !== 128'h0 || u1.ctr !== 5'd0) begin
            errors++;
            $display("FAIL midrun_reset got kr=%b ir=%b ov=%b kl=%b data=%h ctr=%0d want 1 0 0 0 0 0",
                     key_ready[0], in_ready[0], out_valid[0], keys_loaded[0], out_data_a[0], u1.ctr);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); seen |= out_valid[0] | in_ready[0]; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrun_discard got ov/ir=1 want 0"); end
        load_key(0, K0, kc);
        checks++;
        if (kc !== 32) begin errors++; $display("FAIL reload_keyexp got %0d want 32", kc); end
        run_block(0, 1'b0, K0, res, lat);
        checks++;
        if (res !== C0) begin errors++; $display("FAIL reload_encrypt got %h want %h", res, C0); end
    endtask

    task automatic test_unroll;
        logic [127:0] res;
        int kc, lat, u;
        for (int i = 1; i < 3; i++) begin
            u = unroll_of(i);
            load_key(i, K0, kc);
            checks++;
            if (kc !== 32 / u) begin errors++; $display("FAIL unroll%0d_keyexp got %0d want %0d", u, kc, 32 / u); end
            run_block(i, 1'b0, K0, res, lat);
            checks++;
            if (res !== C0) begin errors++; $display("FAIL unroll%0d_data got %h want %h", u, res, C0); end
            checks++;
            if (lat !== 32 / u + 1) begin errors++; $display("FAIL unroll%0d_latency got %0d want %0d", u, lat, 32 / u + 1); end
        end
    endtask

    task automatic test_random;
        logic [127:0] k, d, res, exp;
        bit dec;
        int i, kc, lat;
        for (int it = 0; it < 9; it++) begin
            i   = $urandom_range(0, 2);
            k   = {$urandom(), $urandom(), $urandom(), $urandom()};
            d   = {$urandom(), $urandom(), $urandom(), $urandom()};
            dec = 1'($urandom_range(0, 1));
            load_key(i, k, kc);
            run_block(i, dec, d, res, lat);
            exp = ref_sm4(k, d, dec);
            checks++;
            if (res !== exp || lat !== 32 / unroll_of(i) + 1) begin
                errors++;
                $display("FAIL random%0d inst%0d dec=%0d got %h lat %0d want %h lat %0d",
                         it, i, dec, res, lat, exp, 32 / unroll_of(i) + 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        key_valid = '0; in_valid = '0; in_decrypt = '0; out_ready = '0;
        for (int i = 0; i < 3; i++) begin key_a[i] = '0; in_data_a[i] = '0; end
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_key_priority;
        test_decrypt;
        test_hold;
        test_back_to_back;
        test_reset_midrun;
        test_unroll;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
